ibexc_sleep_ctrl: RTL and testbench

Parametrised core sleep/wake controller for the CHERIoT Ibex top level, generalising the single-flop busy/clock-enable logic into a four-state FSM with idle hysteresis, a configurable wake settling delay, N maskable external wake sources and a sleep-cycle statistics counter. Sits in `ibexc_top` between `clk_i` and the core/regfile clock, driving the gated core clock and `core_sleep_o`. Its own flops always run on ungated `clk_i`.

---
 rtl/ibexc_sleep_ctrl_pkg.sv | 18 +
 rtl/ibexc_sleep_ctrl_if.sv | 29 ++
 rtl/ibexc_sleep_ctrl_sat_counter.sv | 25 ++
 rtl/ibexc_sleep_ctrl.sv | 114 +++++++++++
 tb/tb_ibexc_sleep_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibexc_sleep_ctrl_pkg.sv
// Shared types and helpers for the core sleep/wake controller.
package ibexc_sleep_ctrl_pkg;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    IDLE_WAIT = 2'd1,
    SLEEP     = 2'd2,
    WAKE      = 2'd3
  } sleep_state_e;

  // Width of the shared hysteresis/settling down-counter (never below 1 bit).
  function automatic int unsigned cnt_width(int unsigned idle_hyst, int unsigned wake_delay);
    int unsigned m;
    m = (idle_hyst > wake_delay) ? idle_hyst : wake_delay;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ibexc_sleep_ctrl_if.sv
// Wake-request and sleep-status bundle between the core top level and the
// sleep controller.
interface ibexc_sleep_ctrl_if #(
  parameter int unsigned NumWake   = 4,
  parameter int unsigned SleepCntW = 32
);
  logic                 core_busy_i;
  logic                 irq_pending_i;
  logic                 irq_nm_i;
  logic                 debug_req_i;
  logic [NumWake-1:0]   wake_i;
  logic [NumWake-1:0]   wake_en_i;
  logic                 sleep_cnt_clr_i;
  logic                 clk_en_o;
  logic                 core_sleep_o;
  logic [SleepCntW-1:0] sleep_cnt_o;

  modport slave (
    input  core_busy_i, irq_pending_i, irq_nm_i, debug_req_i,
           wake_i, wake_en_i, sleep_cnt_clr_i,
    output clk_en_o, core_sleep_o, sleep_cnt_o
  );

  modport master (
    output core_busy_i, irq_pending_i, irq_nm_i, debug_req_i,
           wake_i, wake_en_i, sleep_cnt_clr_i,
    input  clk_en_o, core_sleep_o, sleep_cnt_o
  );
endinterface

// File: rtl/ibexc_sleep_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module ibexc_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [Width-1:0] o_cnt
);
  logic [Width-1:0] r_cnt;

  // Count up while enabled, hold at all-ones, clear on request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/ibexc_sleep_ctrl.sv
// Core sleep/wake controller: ACTIVE -> IDLE_WAIT (hysteresis) -> SLEEP ->
// WAKE (settling) -> ACTIVE, plus a saturating sleep-cycle counter.
// Optional macro IBEXC_CLK_GATE_EN: drive clk_o through prim_clock_gating;
// otherwise clk_o is clk_i and the controller only reports status.
module ibexc_sleep_ctrl
  import ibexc_sleep_ctrl_pkg::*;
#(
  parameter int unsigned NumWake   = 4,
  parameter int unsigned IdleHyst  = 8,
  parameter int unsigned WakeDelay = 2,
  parameter int unsigned SleepCntW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               test_en_i,
  output logic               clk_o,
  ibexc_sleep_ctrl_if.slave  bus
);
  localparam int unsigned CntW = cnt_width(IdleHyst, WakeDelay);
  localparam logic [CntW-1:0] IdleLoad = (IdleHyst  == 0) ? '0 : CntW'(IdleHyst - 1);
  localparam logic [CntW-1:0] WakeLoad = (WakeDelay == 0) ? '0 : CntW'(WakeDelay - 1);

  sleep_state_e       r_state, w_state_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic               r_busy_q;
  logic [NumWake-1:0] w_wake_masked;
  logic               w_wake_evt;

  assign w_wake_masked = bus.wake_i & bus.wake_en_i;
  assign w_wake_evt    = bus.irq_pending_i | bus.irq_nm_i | bus.debug_req_i | (|w_wake_masked);

  // State, down-counter and registered busy flag; all on the ungated clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ACTIVE;
      r_cnt    <= '0;
      r_busy_q <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_busy_q <= bus.core_busy_i;
    end
  end

  // Next-state logic; in IDLE_WAIT activity beats hysteresis expiry.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      ACTIVE: begin
        if (!r_busy_q && !w_wake_evt) begin
          if (IdleHyst == 0) begin
            w_state_d = SLEEP;
          end else begin
            w_state_d = IDLE_WAIT;
            w_cnt_d   = IdleLoad;
          end
        end
      end
      IDLE_WAIT: begin
        if (r_busy_q || w_wake_evt) begin
          w_state_d = ACTIVE;
        end else if (r_cnt == '0) begin
          w_state_d = SLEEP;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      SLEEP: begin
        if (w_wake_evt) begin
          if (WakeDelay == 0) begin
            w_state_d = ACTIVE;
          end else begin
            w_state_d = WAKE;
            w_cnt_d   = WakeLoad;
          end
        end
      end
      WAKE: begin
        if (r_cnt == '0) begin
          w_state_d = ACTIVE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = ACTIVE;
    endcase
  end

  assign bus.clk_en_o     = (r_state == ACTIVE) || (r_state == IDLE_WAIT) || test_en_i;
  assign bus.core_sleep_o = (r_state == SLEEP);

  ibexc_sat_counter #(
    .Width (SleepCntW)
  ) u_sleep_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_inc   (r_state == SLEEP),
    .i_clr   (bus.sleep_cnt_clr_i),
    .o_cnt   (bus.sleep_cnt_o)
  );

`ifdef IBEXC_CLK_GATE_EN
  prim_clock_gating u_clk_gate (
    .clk_i     (clk_i),
    .en_i      (bus.clk_en_o),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );
`else
  assign clk_o = clk_i;
`endif

endmodule

// File: tb/tb_ibexc_sleep_ctrl.sv
// Bench for ibexc_sleep_ctrl: two instances sharing stimulus, one with
// hysteresis 8 / wake delay 2 and one with both set to zero.
module tb_ibexc_sleep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_en = 1'b0;
  logic       busy = 1'b1, irq = 1'b0, nm = 1'b0, dbg = 1'b0, clr = 1'b0;
  logic [3:0] wake = '0, wake_en = '0;
  logic       clk_o_a, clk_o_b;

  int errors = 0;
  int checks = 0;

  int hy [2] = '{8, 0};
  int wd [2] = '{2, 0};

  always #5 clk = ~clk;

  ibexc_sleep_ctrl_if #(.NumWake(4), .SleepCntW(8)) ifa ();
  ibexc_sleep_ctrl_if #(.NumWake(4), .SleepCntW(8)) ifb ();

  assign ifa.core_busy_i = busy;    assign ifb.core_busy_i = busy;
  assign ifa.irq_pending_i = irq;   assign ifb.irq_pending_i = irq;
  assign ifa.irq_nm_i = nm;         assign ifb.irq_nm_i = nm;
  assign ifa.debug_req_i = dbg;     assign ifb.debug_req_i = dbg;
  assign ifa.wake_i = wake;         assign ifb.wake_i = wake;
  assign ifa.wake_en_i = wake_en;   assign ifb.wake_en_i = wake_en;
  assign ifa.sleep_cnt_clr_i = clr; assign ifb.sleep_cnt_clr_i = clr;

  ibexc_sleep_ctrl #(.NumWake(4), .IdleHyst(8), .WakeDelay(2), .SleepCntW(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .clk_o(clk_o_a), .bus(ifa.slave));
  ibexc_sleep_ctrl #(.NumWake(4), .IdleHyst(0), .WakeDelay(0), .SleepCntW(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .clk_o(clk_o_b), .bus(ifb.slave));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with an interrupt held so neither instance drops to sleep while
  // the registered busy flag is still at its reset value.
  task automatic do_reset();
    rst_n = 1'b0; busy = 1'b1; irq = 1'b1; nm = 1'b0; dbg = 1'b0; clr = 1'b0;
    wake = '0; wake_en = '0; test_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    irq = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; busy = 1'b1;
    #3;
    if (ifa.clk_en_o !== 1'b1) begin errors++; $display("FAIL rst_clk_en: got %0b expected 1", ifa.clk_en_o); end
    checks++;
    if (ifa.core_sleep_o !== 1'b0) begin errors++; $display("FAIL rst_sleep: got %0b expected 0", ifa.core_sleep_o); end
    checks++;
    if (ifa.sleep_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", ifa.sleep_cnt_o); end
    checks++;
    do_reset();
    tick(5);
    if (ifa.clk_en_o !== 1'b1 || ifb.clk_en_o !== 1'b1) begin
      errors++; $display("FAIL busy_clk_en: got a=%0b b=%0b expected 1 1", ifa.clk_en_o, ifb.clk_en_o);
    end
    checks++;
  endtask

  task automatic test_sleep_entry();
    do_reset();
    tick(8);
    busy = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (ifa.clk_en_o !== (k < 10)) begin
        errors++; $display("FAIL entry_a_k%0d: got %0b expected %0b", k, ifa.clk_en_o, (k < 10));
      end
      checks++;
      if (ifb.core_sleep_o !== (k >= 2)) begin
        errors++; $display("FAIL entry_b_k%0d: got %0b expected %0b", k, ifb.core_sleep_o, (k >= 2));
      end
      checks++;
    end
  endtask

  task automatic test_hyst_abort();
    do_reset();
    busy = 1'b0;
    tick(8);
    busy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (ifa.clk_en_o !== 1'b1 || ifa.core_sleep_o !== 1'b0) begin
        errors++; $display("FAIL hyst_abort_k%0d: got en=%0b sleep=%0b expected en=1 sleep=0",
                           k, ifa.clk_en_o, ifa.core_sleep_o);
      end
      checks++;
    end
  endtask

  task automatic test_wake_mask();
    do_reset();
    busy = 1'b0; wake = 4'b0100; wake_en = 4'b0000;
    tick(60);
    if (ifa.core_sleep_o !== 1'b1 || ifa.sleep_cnt_o !== 8'd50) begin
      errors++; $display("FAIL masked_a: got sleep=%0b cnt=%0d expected sleep=1 cnt=50", ifa.core_sleep_o, ifa.sleep_cnt_o);
    end
    checks++;
    if (ifb.sleep_cnt_o !== 8'd58) begin
      errors++; $display("FAIL masked_b_cnt: got %0d expected 58", ifb.sleep_cnt_o);
    end
    checks++;
    wake_en = 4'b0100;
    tick(1);
    if (ifa.core_sleep_o !== 1'b0 || ifa.clk_en_o !== 1'b0 || ifa.sleep_cnt_o !== 8'd51) begin
      errors++; $display("FAIL wake1_a: got sleep=%0b en=%0b cnt=%0d expected 0 0 51",
                         ifa.core_sleep_o, ifa.clk_en_o, ifa.sleep_cnt_o);
    end
    checks++;
    if (ifb.clk_en_o !== 1'b1 || ifb.core_sleep_o !== 1'b0) begin
      errors++; $display("FAIL wake1_b: got en=%0b sleep=%0b expected 1 0", ifb.clk_en_o, ifb.core_sleep_o);
    end
    checks++;
    tick(1);
    if (ifa.clk_en_o !== 1'b0) begin errors++; $display("FAIL wake2_a: got %0b expected 0", ifa.clk_en_o); end
    checks++;
    tick(1);
    if (ifa.clk_en_o !== 1'b1 || ifa.sleep_cnt_o !== 8'd51) begin
      errors++; $display("FAIL wake3_a: got en=%0b cnt=%0d expected 1 51", ifa.clk_en_o, ifa.sleep_cnt_o);
    end
    checks++;
    wake = '0; wake_en = '0;
  endtask

  task automatic test_saturate();
    do_reset();
    busy = 1'b0;
    tick(310);
    if (ifa.sleep_cnt_o !== 8'd255 || ifb.sleep_cnt_o !== 8'd255) begin
      errors++; $display("FAIL sat: got a=%0d b=%0d expected 255", ifa.sleep_cnt_o, ifb.sleep_cnt_o);
    end
    checks++;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    if (ifa.sleep_cnt_o !== 8'd0 || ifb.sleep_cnt_o !== 8'd0) begin
      errors++; $display("FAIL clr: got a=%0d b=%0d expected 0", ifa.sleep_cnt_o, ifb.sleep_cnt_o);
    end
    checks++;
    tick(2);
    if (ifa.sleep_cnt_o !== 8'd2) begin errors++; $display("FAIL resume: got %0d expected 2", ifa.sleep_cnt_o); end
    checks++;
  endtask

  task automatic test_reset_in_wake();
    do_reset();
    busy = 1'b0;
    tick(10);
    wake = 4'b0100; wake_en = 4'b0100;
    tick(1);
    if (ifa.clk_en_o !== 1'b0 || ifa.sleep_cnt_o !== 8'd1) begin
      errors++; $display("FAIL pre_rst_wake: got en=%0b cnt=%0d expected 0 1", ifa.clk_en_o, ifa.sleep_cnt_o);
    end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if (ifa.clk_en_o !== 1'b1 || ifa.core_sleep_o !== 1'b0 || ifa.sleep_cnt_o !== 8'd0) begin
      errors++; $display("FAIL rst_in_wake: got en=%0b sleep=%0b cnt=%0d expected 1 0 0",
                         ifa.clk_en_o, ifa.core_sleep_o, ifa.sleep_cnt_o);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    if (ifa.clk_en_o !== 1'b1) begin errors++; $display("FAIL post_rst: got %0b expected 1", ifa.clk_en_o); end
    checks++;
    wake = '0; wake_en = '0;
  endtask

  task automatic test_test_en();
    do_reset();
    busy = 1'b0;
    tick(10);
    test_en = 1'b1;
    #1;
    if (ifa.clk_en_o !== 1'b1 || ifa.core_sleep_o !== 1'b1) begin
      errors++; $display("FAIL test_en_on: got en=%0b sleep=%0b expected 1 1", ifa.clk_en_o, ifa.core_sleep_o);
    end
    checks++;
    test_en = 1'b0;
    #1;
    if (ifa.clk_en_o !== 1'b0) begin errors++; $display("FAIL test_en_off: got %0b expected 0", ifa.clk_en_o); end
    checks++;
  endtask

  // Reference: awake after H+1 consecutive quiet cycles goes to sleep; a
  // wake event while asleep re-enables the clock D cycles later.
  task automatic test_random();
    int  mode [2];
    int  quiet [2];
    int  left [2];
    int  cnt [2];
    bit  bprev [2];
    bit  wk, g_en, g_sl;
    int  g_cnt;
    rst_n = 1'b0; busy = 1'b1; irq = 1'b0; nm = 1'b0; dbg = 1'b0; clr = 1'b0;
    wake = '0; wake_en = '0; test_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; quiet[i] = 0; left[i] = 0; cnt[i] = 0; bprev[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      wk = irq | nm | dbg | (|(wake & wake_en));
      for (int i = 0; i < 2; i++) begin
        if (clr) cnt[i] = 0;
        else if (mode[i] == 1 && cnt[i] < 255) cnt[i]++;
        case (mode[i])
          0: if (bprev[i] || wk) quiet[i] = 0;
             else begin
               quiet[i]++;
               if (quiet[i] > hy[i]) begin mode[i] = 1; quiet[i] = 0; end
             end
          1: if (wk) begin
               if (wd[i] == 0) mode[i] = 0;
               else begin mode[i] = 2; left[i] = wd[i]; end
             end
          default: begin
            left[i]--;
            if (left[i] == 0) mode[i] = 0;
          end
        endcase
        bprev[i] = busy;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        g_en  = (i == 0) ? ifa.clk_en_o : ifb.clk_en_o;
        g_sl  = (i == 0) ? ifa.core_sleep_o : ifb.core_sleep_o;
        g_cnt = (i == 0) ? int'(ifa.sleep_cnt_o) : int'(ifb.sleep_cnt_o);
        if (g_en !== ((mode[i] == 0) || test_en)) begin
          errors++; $display("FAIL rnd_en dut%0d cyc%0d: got %0b expected %0b", i, c, g_en, ((mode[i] == 0) || test_en));
        end
        checks++;
        if (g_sl !== (mode[i] == 1)) begin
          errors++; $display("FAIL rnd_sleep dut%0d cyc%0d: got %0b expected %0b", i, c, g_sl, (mode[i] == 1));
        end
        checks++;
        if (g_cnt != cnt[i]) begin
          errors++; $display("FAIL rnd_cnt dut%0d cyc%0d: got %0d expected %0d", i, c, g_cnt, cnt[i]);
        end
        checks++;
      end
      if ($urandom_range(0, 15) == 0) busy = ~busy;
      if ($urandom_range(0, 9) == 0) wake = 4'($urandom);
      if ($urandom_range(0, 39) == 0) wake_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      irq = ($urandom_range(0, 39) == 0);
      nm  = ($urandom_range(0, 199) == 0);
      dbg = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) test_en = ~test_en;
    end
  endtask

  initial begin
    test_reset();
    test_sleep_entry();
    test_hyst_abort();
    test_wake_mask();
    test_saturate();
    test_reset_in_wake();
    test_test_en();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
